// File: rtl/operand_prep.sv
// Front end of the FP adder: unpacks an operand pair, orders it by
// exponent and hands it to the adder Control block with a Go pulse.
module operand_prep #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [EXPBITS+MANTISSABITS:0] A,
  input  logic [EXPBITS+MANTISSABITS:0] B,
  input  logic                    Done,
  output logic                    Go,
  output logic                    ExpSet,
  output logic [EXPBITS-1:0]      ExpDiff,
  output logic [EXPBITS-1:0]      BigExp,
  output logic [MANTISSABITS:0]   BigMan,
  output logic [MANTISSABITS:0]   SmallMan,
  output logic                    BigSign,
  output logic                    SmallSign,
  output logic                    Special
);

  localparam int W = 1 + EXPBITS + MANTISSABITS;
  localparam int M = MANTISSABITS;
  localparam int E = EXPBITS;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    ISSUE,
    BUSY
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] a_q, b_q;
  logic         go_q, go_d;
  logic         set_q;
  logic [E-1:0] diff_q, bexp_q;
  logic [M:0]   bman_q, sman_q;
  logic         bsgn_q, ssgn_q;

  logic [E-1:0] ea_raw, eb_raw, ea, eb;
  logic [M:0]   ma, mb;
  logic         a_ge, spec_w, take, load;

  always_comb begin
    ea_raw = a_q[W-2:M];
    eb_raw = b_q[W-2:M];
    ea     = (|ea_raw) ? ea_raw : E'(1);
    eb     = (|eb_raw) ? eb_raw : E'(1);
    ma     = {|ea_raw, a_q[M-1:0]};
    mb     = {|eb_raw, b_q[M-1:0]};
    a_ge   = ea >= eb;
    spec_w = (&ea_raw) | (&eb_raw);
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    load    = 1'b0;
    go_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          take    = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        load    = !spec_w;
        state_d = spec_w ? IDLE : ISSUE;
      end
      ISSUE: begin
        go_d    = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        // Done coinciding with the Go pulse belongs to the previous op
        if (Done && !go_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      set_q   <= 1'b0;
      diff_q  <= '0;
      bexp_q  <= '0;
      bman_q  <= '0;
      sman_q  <= '0;
      bsgn_q  <= 1'b0;
      ssgn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      if (take) begin
        a_q <= A;
        b_q <= B;
      end
      if (load) begin
        set_q  <= a_ge;
        diff_q <= a_ge ? (ea - eb) : (eb - ea);
        bexp_q <= a_ge ? ea : eb;
        bman_q <= a_ge ? ma : mb;
        sman_q <= a_ge ? mb : ma;
        bsgn_q <= a_ge ? a_q[W-1] : b_q[W-1];
        ssgn_q <= a_ge ? b_q[W-1] : a_q[W-1];
      end
    end
  end

  assign InReady   = (state_q == IDLE) && !Reset;
  assign Special   = (state_q == CMP) && spec_w && !Reset;
  assign Go        = go_q;
  assign ExpSet    = set_q;
  assign ExpDiff   = diff_q;
  assign BigExp    = bexp_q;
  assign BigMan    = bman_q;
  assign SmallMan  = sman_q;
  assign BigSign   = bsgn_q;
  assign SmallSign = ssgn_q;

endmodule
